// File: rtl/writeback_queue_if.sv
// Writeback queue bus: single-cycle ALU results, load results with valid/ready,
// decode-stage hazard query and the registered register-file write port.
`ifndef RegAddrBits
`define RegAddrBits 5
`endif
`ifndef DataBusBits
`define DataBusBits 32
`endif

interface writeback_queue_if;
    // A load transfers on a rising edge where mem_valid && mem_ready; the sender
    // holds mem_rd/mem_data stable while mem_valid is high without mem_ready.
    // The ALU path has no ready: alu_valid is a one-cycle pulse that is always taken.
    logic                      alu_valid;
    logic [`RegAddrBits-1:0]   alu_rd;
    logic [`DataBusBits-1:0]   alu_data;
    logic                      mem_valid;
    logic                      mem_ready;
    logic [`RegAddrBits-1:0]   mem_rd;
    logic [`DataBusBits-1:0]   mem_data;
    logic [`RegAddrBits-1:0]   hz_addr1;
    logic [`RegAddrBits-1:0]   hz_addr2;
    logic                      stall;
    logic                      we;
    logic [`RegAddrBits-1:0]   saddr;
    logic [`DataBusBits-1:0]   wdata;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               hz_addr1, hz_addr2,
        output mem_ready, stall, we, saddr, wdata
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               hz_addr1, hz_addr2,
        input  mem_ready, stall, we, saddr, wdata
    );
endinterface

// File: rtl/writeback_queue.sv
// Register-file writeback arbiter: ALU results win, loads wait in an in-order FIFO.
// Define WBQ_STATS_EN to add the bp_cycles back-pressure counter output.
`ifndef RegAddrBits
`define RegAddrBits 5
`endif
`ifndef DataBusBits
`define DataBusBits 32
`endif

module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef WBQ_STATS_EN
    output logic [15:0]        bp_cycles,
`endif
    writeback_queue_if.slave   wbq
);
    localparam int RA = `RegAddrBits;
    localparam int DW = `DataBusBits;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [DEPTH-1:0] r_valid;
    logic [RA-1:0]  r_rd   [DEPTH];
    logic [DW-1:0]  r_data [DEPTH];
    logic           r_we;
    logic [RA-1:0]  r_saddr;
    logic [DW-1:0]  r_wdata;

    logic           w_empty;
    logic           w_full;
    logic           w_ready;
    logic           w_accept;
    logic           w_pop;
    logic           w_direct;
    logic           w_push;
    logic           w_nxt_we;
    logic [RA-1:0]  w_nxt_saddr;
    logic [DW-1:0]  w_nxt_wdata;
    logic           w_stall;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_ready  = rst & ~w_full;
    assign w_accept = wbq.mem_valid & w_ready;
    assign w_pop    = ~wbq.alu_valid & ~w_empty;
    assign w_direct = ~wbq.alu_valid & w_empty & w_accept;
    // A load racing an ALU write to the same register is older, so it is dropped.
    assign w_push   = w_accept & ~w_direct & (wbq.mem_rd != '0)
                    & ~(wbq.alu_valid & (wbq.mem_rd == wbq.alu_rd));

    always_comb begin
        w_nxt_we    = 1'b0;
        w_nxt_saddr = r_saddr;
        w_nxt_wdata = r_wdata;
        if (wbq.alu_valid) begin
            if (wbq.alu_rd != '0) begin
                w_nxt_we    = 1'b1;
                w_nxt_saddr = wbq.alu_rd;
                w_nxt_wdata = wbq.alu_data;
            end
        end else if (!w_empty) begin
            // A killed head still consumes its slot, it just writes nothing.
            if (r_valid[r_rd_ptr]) begin
                w_nxt_we    = 1'b1;
                w_nxt_saddr = r_rd[r_rd_ptr];
                w_nxt_wdata = r_data[r_rd_ptr];
            end
        end else if (w_accept && (wbq.mem_rd != '0)) begin
            w_nxt_we    = 1'b1;
            w_nxt_saddr = wbq.mem_rd;
            w_nxt_wdata = wbq.mem_data;
        end
    end

    always_comb begin
        w_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (wbq.hz_addr1 != '0) && (r_rd[i] == wbq.hz_addr1)) w_stall = 1'b1;
            if (r_valid[i] && (wbq.hz_addr2 != '0) && (r_rd[i] == wbq.hz_addr2)) w_stall = 1'b1;
        end
        if (r_we && (wbq.hz_addr1 != '0) && (r_saddr == wbq.hz_addr1)) w_stall = 1'b1;
        if (r_we && (wbq.hz_addr2 != '0) && (r_saddr == wbq.hz_addr2)) w_stall = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_we     <= 1'b0;
            r_saddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_we    <= w_nxt_we;
            r_saddr <= w_nxt_saddr;
            r_wdata <= w_nxt_wdata;
            for (int i = 0; i < DEPTH; i++) begin
                if (wbq.alu_valid && (wbq.alu_rd != '0) && (r_rd[i] == wbq.alu_rd))
                    r_valid[i] <= 1'b0;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wr_ptr]   <= wbq.mem_rd;
            r_data[r_wr_ptr] <= wbq.mem_data;
        end
    end

`ifdef WBQ_STATS_EN
    logic [15:0] r_bp_cycles;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bp_cycles <= '0;
        end else if (wbq.mem_valid && !w_ready && (r_bp_cycles != 16'hFFFF)) begin
            r_bp_cycles <= r_bp_cycles + 16'd1;
        end
    end

    assign bp_cycles = r_bp_cycles;
`endif

    assign wbq.mem_ready = w_ready;
    assign wbq.stall     = w_stall;
    assign wbq.we        = r_we;
    assign wbq.saddr     = r_saddr;
    assign wbq.wdata     = r_wdata;
endmodule
